// File: rtl/tnn_feature_packer.sv
// Quantizes raw features to 3 bits and packs five per bundle for the ternary
// neuron comparators, with a registered, double-buffered valid/ready output.
module tnn_feature_packer #(
  parameter int FEAT_W = 10,
  parameter int SHIFT  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FEAT_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_a,
  output logic [2:0]        out_b,
  output logic [2:0]        out_c,
  output logic [2:0]        out_d,
  output logic [2:0]        out_e,
  output logic              len_err,
  output logic [CNT_W-1:0]  bundle_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  localparam logic [FEAT_W-1:0] QMAX    = FEAT_W'(7);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic [2:0]       idx_q;
  logic [4:0][2:0]  coll_q;
  logic [4:0][2:0]  out_q;
  logic             pend_q;
  logic             out_valid_q;
  logic             len_err_q;
  logic [CNT_W-1:0] bundle_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic [FEAT_W-1:0] shifted;
  logic [2:0]        q;
  logic              accept;
  logic              out_fire;
  logic              out_free;

  assign shifted  = in_data >> SHIFT;
  assign q        = (shifted > QMAX) ? 3'd7 : shifted[2:0];
  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;
  assign out_free = ~out_valid_q | out_ready;

  // A handshake clears out_valid unless a new bundle is loaded on the same edge,
  // which is what keeps back-to-back bundles free of bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= COLLECT;
      idx_q        <= 3'd0;
      coll_q       <= '0;
      pend_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      len_err_q    <= 1'b0;
      bundle_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      len_err_q <= 1'b0;
      if (out_fire) begin
        bundle_cnt_q <= bundle_cnt_q + CNT_ONE;
        out_valid_q  <= 1'b0;
      end
      case (state_q)
        COLLECT: begin
          if (accept) begin
            if (idx_q != 3'd4) begin
              if (in_last) begin
                idx_q     <= 3'd0;
                len_err_q <= 1'b1;
                err_cnt_q <= err_cnt_q + CNT_ONE;
              end else begin
                coll_q[idx_q[1:0]] <= q;
                idx_q              <= idx_q + 3'd1;
              end
            end else begin
              idx_q <= 3'd0;
              if (out_free) begin
                out_q       <= {q, coll_q[3:0]};
                out_valid_q <= 1'b1;
                state_q     <= in_last ? COLLECT : DISCARD;
              end else begin
                coll_q[4] <= q;
                pend_q    <= ~in_last;
                state_q   <= HOLD;
              end
              // A sample still running after its fifth feature is too long.
              if (!in_last) begin
                len_err_q <= 1'b1;
                err_cnt_q <= err_cnt_q + CNT_ONE;
              end
            end
          end
        end
        HOLD: begin
          if (out_fire) begin
            out_q       <= coll_q;
            out_valid_q <= 1'b1;
            state_q     <= pend_q ? DISCARD : COLLECT;
            pend_q      <= 1'b0;
          end
        end
        DISCARD: begin
          if (accept && in_last) begin
            state_q <= COLLECT;
            idx_q   <= 3'd0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_a      = out_q[0];
  assign out_b      = out_q[1];
  assign out_c      = out_q[2];
  assign out_d      = out_q[3];
  assign out_e      = out_q[4];
  assign len_err    = len_err_q;
  assign bundle_cnt = bundle_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: doc/tnn_feature_packer.md
Name: tnn_feature_packer

Overview:
- Input-side producer for the 5-operand, 3-bit ternary neuron comparators in the whitewine 3-bit library.
- Accepts raw unsigned features one per cycle over a valid/ready stream.
- Quantizes each feature to 3 bits with saturation and groups five consecutive features into one bundle (operands a..e).
- Presents each bundle on a registered, double-buffered valid/ready output, so feature intake continues while the neuron side stalls.

Parameters:
- FEAT_W, 10, width of raw input feature (must be >= SHIFT+1).
- SHIFT, 5, right-shift applied before saturation to 3 bits.
- CNT_W, 16, width of emitted-bundle and error counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  feature present.
- in_ready  output  1  packer can accept a feature.
- in_data  input  FEAT_W  raw unsigned feature.
- in_last  input  1  marks final feature of a sample.
- out_valid  output  1  bundle available.
- out_ready  input  1  consumer accepts bundle.
- out_a, out_b, out_c, out_d, out_e  output  3 each  quantized features 0..4 of the bundle.
- len_err  output  1  one-cycle pulse on a sample length violation.
- bundle_cnt  output  CNT_W  bundles handed off (out_valid & out_ready), wraps modulo 2^CNT_W.
- err_cnt  output  CNT_W  length violations, wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock domain. rst is asynchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_a..out_e=0, len_err=0, both counters 0, idx=0, state=COLLECT, collection register cleared.
- Reset mid-operation drops any partial sample and any pending output bundle.
- Quantization (combinational on intake): q = (in_data >> SHIFT) > 7 ? 7 : (in_data >> SHIFT)[2:0].
- Feature accept occurs when in_valid & in_ready.
- idx (0..4) selects the collection slot: 0->a, 1->b, 2->c, 3->d, 4->e.
- Output register is free this cycle when !out_valid | out_ready.
- State COLLECT: in_ready=1.
  - Accept with idx<4 and !in_last: store q in slot idx; idx++.
  - Accept with idx<4 and in_last (short sample): discard the partial sample; idx=0; len_err=1 next cycle; err_cnt++.
  - Accept with idx==4: complete the bundle (the 5th feature goes into slot e).
    - Output free: load out_a..out_e from the bundle; out_valid=1 next cycle; idx=0.
    - Output not free: hold the bundle in the collection register; go to HOLD.
    - If in_last=0 (long sample): also go to DISCARD after the bundle is placed, flag len_err and increment err_cnt once. If the bundle went to HOLD, the DISCARD entry is remembered and taken on exit from HOLD.
- State HOLD: in_ready=0.
  - On out_valid & out_ready: load the collection register into the output register in the same edge, so out_valid stays 1 with no bubble.
  - Next state is COLLECT, or DISCARD if pending.
- State DISCARD: in_ready=1; features are accepted and dropped. On an accept with in_last, go to COLLECT with idx=0.
- Output handshake:
  - out_valid falls only after out_valid & out_ready with no new bundle loaded that edge.
  - out_a..out_e are stable while out_valid & !out_ready.
  - bundle_cnt increments on each out_valid & out_ready.
- Latency: a bundle is visible on outputs 1 cycle after its 5th feature is accepted (output free). Best-case throughput is 1 bundle per 5 cycles.
- Simultaneous events: 5th-feature accept in the same cycle as output handshake counts as output free, so back-to-back bundles load with no stall.
- Counters: bundle_cnt and err_cnt wrap without saturating and never stall the datapath.

Test Plan:
- Reset then 5 features 0,32,64,96,1023 with in_last on the 5th, out_ready=1 -> out_a..e=0,1,2,3,7 (saturated); out_valid for 1 cycle, 1 cycle after the 5th accept; bundle_cnt=1.
- Hold out_ready=0 and stream 10 features (two samples) -> first bundle held stable; in_ready=0 after the 10th accept (HOLD). Raise out_ready -> second bundle appears the next cycle with no out_valid gap; bundle_cnt=2.
- Short sample: 3 features, in_last on the 3rd -> len_err pulses once, err_cnt=1, no bundle. The next 5-feature sample emits normally with values in slots a..e.
- Long sample: 7 features, in_last on the 7th -> bundle from features 1-5 emitted; features 6-7 dropped; len_err once; err_cnt=1; the following sample aligns to slot a.
- Assert rst asynchronously mid-sample (idx=3) and during HOLD -> out_valid=0 and in_ready=1 immediately. The next sample starts at slot a, with counters at 0.
- Continuous stream of 65536 valid samples with out_ready=1 (CNT_W=16) -> bundle_cnt wraps to 0; out_valid cadence is 1 per 5 cycles.
